mem_port_arbiter: RTL and testbench

Shares the single-ported unified memory between the IF-stage instruction fetch and the M-stage load/store path of the pipelined MIPS core. It sequences each access as a variable-latency bus transaction with a ready handshake. It converts M-stage access mode (word/half/byte) into byte enables, store-lane replication and load extension. It drives per-stage stall signals, alternates grants when both requesters contend, and resolves misaligned data accesses without touching memory.

---
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the M-stage load/store path.
// Sequences ready-handshake bus transactions, alternates grants on contention, flags misaligned data accesses.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              m_read,
  input  logic              m_write,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  input  logic [1:0]        m_mode,
  input  logic              m_sign,
  output logic [DATA_W-1:0] m_rdata,
  output logic              m_done,
  output logic              m_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall_if,
  output logic              stall_m
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, ERR} state_t;

  state_t              state_q, state_d;
  logic                lastGrant_q, lastGrant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [3:0]          be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          mode_q, mode_d;
  logic                sign_q, sign_d;

  logic                decide, fetchCand, dataCand, pickData;
  logic                misaligned, busActive, dataDone;
  logic [3:0]          reqBe;
  logic [DATA_W-1:0]   reqWdata, loadData, shifted;
  logic [15:0]         halfV;
  logic [7:0]          byteV;

  // Lane mapping of the incoming M-stage request; mode 3 falls through to word.
  always_comb begin
    reqBe      = 4'hF;
    reqWdata   = m_wdata;
    misaligned = (m_addr[1:0] != 2'b00);
    case (m_mode)
      2'd1: begin
        reqBe      = m_addr[1] ? 4'b1100 : 4'b0011;
        reqWdata   = {2{m_wdata[15:0]}};
        misaligned = m_addr[0];
      end
      2'd2: begin
        reqBe      = 4'b0001 << m_addr[1:0];
        reqWdata   = {4{m_wdata[7:0]}};
        misaligned = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    addr_d      = addr_q;
    we_d        = we_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    mode_d      = mode_q;
    sign_d      = sign_q;

    // The requester that just finished is excluded so it cannot be re-granted back to back.
    decide    = (state_q == IDLE) || (state_q == ERR) ||
                (((state_q == FETCH) || (state_q == DATA)) && mem_ready);
    fetchCand = if_req && (state_q != FETCH);
    dataCand  = (m_read || m_write) && (state_q != DATA) && (state_q != ERR);
    pickData  = dataCand && (!fetchCand || !lastGrant_q);

    if (decide) begin
      state_d = IDLE;
      if (pickData) begin
        state_d     = misaligned ? ERR : DATA;
        lastGrant_d = 1'b1;
        addr_d      = m_addr;
        we_d        = m_write;
        be_d        = reqBe;
        wdata_d     = reqWdata;
        mode_d      = m_mode;
        sign_d      = m_sign;
      end else if (fetchCand) begin
        state_d     = FETCH;
        lastGrant_d = 1'b0;
        addr_d      = if_addr;
        we_d        = 1'b0;
        be_d        = 4'hF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= 4'h0;
      wdata_q     <= '0;
      mode_q      <= 2'd0;
      sign_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      mode_q      <= mode_d;
      sign_q      <= sign_d;
    end
  end

  // Load lane select and extension from the latched address and mode.
  always_comb begin
    shifted  = mem_rdata >> {addr_q[1:0], 3'b000};
    byteV    = shifted[7:0];
    halfV    = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    loadData = mem_rdata;
    case (mode_q)
      2'd1:    loadData = {{16{sign_q & halfV[15]}}, halfV};
      2'd2:    loadData = {{24{sign_q & byteV[7]}}, byteV};
      default: ;
    endcase
  end

  assign busActive = (state_q == FETCH) || (state_q == DATA);
  assign dataDone  = (state_q == DATA) && mem_ready && !reset;

  assign if_done   = (state_q == FETCH) && mem_ready && !reset;
  assign if_rdata  = if_done ? mem_rdata : '0;
  assign m_done    = dataDone || (state_q == ERR);
  assign m_err     = (state_q == ERR);
  assign m_rdata   = (dataDone && !we_q) ? loadData : '0;

  assign mem_req   = busActive;
  assign mem_we    = (state_q == DATA) && we_q;
  assign mem_addr  = busActive ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_be    = busActive ? be_q : 4'h0;
  assign mem_wdata = mem_we ? wdata_q : '0;

  assign stall_if  = if_req && !if_done;
  assign stall_m   = (m_read || m_write) && !m_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch timing, lane mapping, contention, misalignment and reset abort.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [1:0]  m_mode;
  logic        m_sign;
  logic [31:0] m_rdata;
  logic        m_done;
  logic        m_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall_if;
  logic        stall_m;

  int checkCount;
  int errorCount;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_mode(m_mode), .m_sign(m_sign), .m_rdata(m_rdata), .m_done(m_done), .m_err(m_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_m(stall_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [1:0] mode, input logic sgn);
    m_read  = rd;
    m_write = wr;
    m_addr  = addr;
    m_wdata = wdata;
    m_mode  = mode;
    m_sign  = sgn;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    reset = 1'b1;
    if_req = 1'b0;
    if_addr = 32'h0;
    mem_rdata = 32'h0;
    mem_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    repeat (2) nextCycle();
    #1;
    checkOutput("rst_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("rst_mem_be", {28'b0, mem_be}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_dones", {30'b0, if_done, m_done}, 32'd0);

    // Fetch at 0x100 with two wait states
    reset = 1'b0;
    if_req = 1'b1;
    if_addr = 32'h100;
    #1;
    checkOutput("f_stall_pre", {31'b0, stall_if}, 32'd1);
    checkOutput("f_req_pre", {31'b0, mem_req}, 32'd0);
    nextCycle(); #1;
    checkOutput("f_req_w1", {31'b0, mem_req}, 32'd1);
    checkOutput("f_be", {28'b0, mem_be}, 32'hF);
    checkOutput("f_addr", mem_addr, 32'h100);
    checkOutput("f_we", {31'b0, mem_we}, 32'd0);
    checkOutput("f_done_w1", {31'b0, if_done}, 32'd0);
    nextCycle(); #1;
    checkOutput("f_req_w2", {31'b0, mem_req}, 32'd1);
    checkOutput("f_stall_w2", {31'b0, stall_if}, 32'd1);
    nextCycle();
    mem_ready = 1'b1;
    mem_rdata = 32'h12345678;
    #1;
    checkOutput("f_req_w3", {31'b0, mem_req}, 32'd1);
    checkOutput("f_done", {31'b0, if_done}, 32'd1);
    checkOutput("f_rdata", if_rdata, 32'h12345678);
    checkOutput("f_stall_done", {31'b0, stall_if}, 32'd0);
    nextCycle();
    if_req = 1'b0;
    mem_ready = 1'b0;
    #1;
    checkOutput("f_req_after", {31'b0, mem_req}, 32'd0);

    // Byte store at 0x203
    applyStimulus(1'b0, 1'b1, 32'h203, 32'h000000AB, 2'd2, 1'b0);
    #1;
    checkOutput("sb_stall_pre", {31'b0, stall_m}, 32'd1);
    nextCycle(); #1;
    checkOutput("sb_req", {31'b0, mem_req}, 32'd1);
    checkOutput("sb_we", {31'b0, mem_we}, 32'd1);
    checkOutput("sb_addr", mem_addr, 32'h200);
    checkOutput("sb_be", {28'b0, mem_be}, 32'h8);
    checkOutput("sb_wdata", mem_wdata, 32'hABABABAB);
    checkOutput("sb_done_wait", {31'b0, m_done}, 32'd0);
    mem_ready = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    #1;
    checkOutput("sb_done", {30'b0, m_done, m_err}, 32'd2);
    checkOutput("sb_rdata", m_rdata, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    mem_ready = 1'b0;

    // Signed then unsigned half load at 0x102
    applyStimulus(1'b1, 1'b0, 32'h102, 32'h0, 2'd1, 1'b1);
    nextCycle();
    mem_ready = 1'b1;
    mem_rdata = 32'h80017FFF;
    #1;
    checkOutput("lh_be", {28'b0, mem_be}, 32'hC);
    checkOutput("lh_we", {31'b0, mem_we}, 32'd0);
    checkOutput("lh_done", {31'b0, m_done}, 32'd1);
    checkOutput("lh_signed", m_rdata, 32'hFFFF8001);
    nextCycle();
    mem_ready = 1'b0;
    m_sign = 1'b0;
    #1;
    checkOutput("lh_idle_gap", {31'b0, mem_req}, 32'd0);
    nextCycle();
    mem_ready = 1'b1;
    #1;
    checkOutput("lh_unsigned", m_rdata, 32'h00008001);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    mem_ready = 1'b0;

    // Fresh reset, then contention with zero-wait memory: D,F,D,F
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    #1;
    checkOutput("c_rst_req", {31'b0, mem_req}, 32'd0);
    if_req = 1'b1;
    if_addr = 32'h300;
    applyStimulus(1'b1, 1'b0, 32'h400, 32'h0, 2'd0, 1'b0);
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) begin
      nextCycle(); #1;
      checkOutput($sformatf("c_req_%0d", i), {31'b0, mem_req}, 32'd1);
      checkOutput($sformatf("c_addr_%0d", i), mem_addr, (i % 2 == 0) ? 32'h400 : 32'h300);
      checkOutput($sformatf("c_dones_%0d", i), {30'b0, if_done, m_done},
                  (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    checkOutput("c_if_rdata", if_rdata, 32'hCAFEF00D);
    m_read = 1'b0;
    nextCycle(); #1;
    checkOutput("c_idle_end", {31'b0, mem_req}, 32'd0);
    if_req = 1'b0;
    mem_ready = 1'b0;

    // Misaligned word load at 0x102 with a pending fetch
    if_req = 1'b1;
    if_addr = 32'h500;
    applyStimulus(1'b1, 1'b0, 32'h102, 32'h0, 2'd0, 1'b0);
    nextCycle(); #1;
    checkOutput("e_req", {31'b0, mem_req}, 32'd0);
    checkOutput("e_done_err", {30'b0, m_done, m_err}, 32'd3);
    checkOutput("e_stall_m", {31'b0, stall_m}, 32'd0);
    nextCycle(); #1;
    checkOutput("e_fetch_req", {31'b0, mem_req}, 32'd1);
    checkOutput("e_fetch_addr", mem_addr, 32'h500);
    checkOutput("e_err_clear", {31'b0, m_err}, 32'd0);
    m_read = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h0BADF00D;
    #1;
    checkOutput("e_fetch_done", if_rdata, 32'h0BADF00D);
    nextCycle();
    if_req = 1'b0;
    mem_ready = 1'b0;

    // Reset during a data transaction abandons it
    applyStimulus(1'b0, 1'b1, 32'h600, 32'h11223344, 2'd0, 1'b0);
    nextCycle(); #1;
    checkOutput("r_wdata", mem_wdata, 32'h11223344);
    checkOutput("r_be", {28'b0, mem_be}, 32'hF);
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    #1;
    checkOutput("r_req", {31'b0, mem_req}, 32'd0);
    checkOutput("r_no_done", {31'b0, m_done}, 32'd0);
    checkOutput("r_stall_m", {31'b0, stall_m}, 32'd1);
    nextCycle(); #1;
    checkOutput("r_regrant", {31'b0, mem_req}, 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    nextCycle();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
